// File: rtl/counter_access_arbiter_pkg.sv
// Shared constants and helpers for the counter access arbiter.
package counter_access_arbiter_pkg;

  // Requester direction encoding on the dir bus
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Default configuration
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 4;
  localparam int DEF_MAX_VAL = 15;

  // Outcome of one arbitration cycle on the shared count
  typedef enum logic [1:0] {
    OP_NONE   = 2'd0,  // nothing eligible, state holds
    OP_STEP   = 2'd1,  // granted op moves the count by one
    OP_REJECT = 2'd2,  // granted op blocked by saturation
    OP_CLEAR  = 2'd3   // synchronous clear wins over everything
  } op_e;

  // Width of an index into a vector of n requesters (at least 1 bit)
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/counter_access_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first eligible index at or after rr_ptr.
module rr_arbiter
  import counter_access_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int PTR_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] winner_oh,
  output logic               valid,
  output logic [PTR_W-1:0]   winner_idx
);

  // Index rr_ptr+k reduced modulo NUM_REQ; rr_ptr is always < NUM_REQ
  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                input int               k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PTR_W'(s);
  endfunction

  // Walk the ring from rr_ptr and latch onto the first eligible requester
  always_comb begin
    winner_oh  = '0;
    valid      = 1'b0;
    winner_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!valid && eligible[wrap_idx(rr_ptr, k)]) begin
        valid                           = 1'b1;
        winner_idx                      = wrap_idx(rr_ptr, k);
        winner_oh[wrap_idx(rr_ptr, k)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_access_arbiter.sv
// Shared saturating up/down counter, one round-robin-granted step per clock.
module counter_access_arbiter
  import counter_access_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MAX_VAL = DEF_MAX_VAL
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] dir,
  output logic [NUM_REQ-1:0] gnt,
  output logic               reject,
  output logic [WIDTH-1:0]   count,
  output logic               at_max,
  output logic               at_min
);

  localparam int               PTR_W   = idx_width(NUM_REQ);
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_VAL);
  localparam logic [PTR_W-1:0] LAST_IX = PTR_W'(NUM_REQ - 1);

  logic [WIDTH-1:0]   count_q,  count_d;
  logic [NUM_REQ-1:0] gnt_q,    gnt_d;
  logic               reject_q, reject_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] win_oh;
  logic               win_valid;
  logic [PTR_W-1:0]   win_idx;
  logic               win_dir;
  op_e                op;

  // A requester granted last cycle is masked so it is never granted twice in a row
  assign eligible = req & ~gnt_q;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .eligible   (eligible),
    .rr_ptr     (rr_ptr_q),
    .winner_oh  (win_oh),
    .valid      (win_valid),
    .winner_idx (win_idx)
  );

  assign win_dir = dir[win_idx];

  // Classify this cycle: clear, saturated reject, a real step, or idle
  always_comb begin
    op = OP_NONE;
    if (clear) begin
      op = OP_CLEAR;
    end else if (win_valid) begin
      if (win_dir == DIR_UP) begin
        op = (count_q < MAX_CNT) ? OP_STEP : OP_REJECT;
      end else begin
        op = (count_q != '0) ? OP_STEP : OP_REJECT;
      end
    end
  end

  // Next-state for count, grant, reject flag and round-robin pointer
  always_comb begin
    count_d  = count_q;
    gnt_d    = '0;
    reject_d = 1'b0;
    rr_ptr_d = rr_ptr_q;
    case (op)
      OP_CLEAR: begin
        count_d = '0;
      end
      OP_STEP: begin
        gnt_d    = win_oh;
        rr_ptr_d = (win_idx == LAST_IX) ? '0 : win_idx + 1'b1;
        count_d  = (win_dir == DIR_UP) ? count_q + 1'b1 : count_q - 1'b1;
      end
      OP_REJECT: begin
        gnt_d    = win_oh;
        rr_ptr_d = (win_idx == LAST_IX) ? '0 : win_idx + 1'b1;
        reject_d = 1'b1;
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  // State registers; reset drops any in-flight grant immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      gnt_q    <= '0;
      reject_q <= 1'b0;
      rr_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      gnt_q    <= gnt_d;
      reject_q <= reject_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign gnt    = gnt_q;
  assign reject = reject_q;
  assign count  = count_q;
  assign at_max = (count_q == MAX_CNT);
  assign at_min = (count_q == '0);

endmodule

// File: tb/tb_counter_access_arbiter.sv
// Directed bench for counter_access_arbiter with hand-computed expectations.
module tb_counter_access_arbiter;

  logic       clk;
  logic       reset;
  logic       clear;
  logic [3:0] req;
  logic [3:0] dir;
  logic [3:0] gnt;
  logic       reject;
  logic [3:0] count;
  logic       at_max;
  logic       at_min;

  int n_chk = 0;
  int n_err = 0;

  counter_access_arbiter #(
    .NUM_REQ (4),
    .WIDTH   (4),
    .MAX_VAL (15)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .req    (req),
    .dir    (dir),
    .gnt    (gnt),
    .reject (reject),
    .count  (count),
    .at_max (at_max),
    .at_min (at_min)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [3:0] e_gnt, input logic e_rej,
                           input logic [3:0] e_cnt, input logic [1:0] e_ptr);
    chk({tag, ".gnt"},    32'(gnt),           32'(e_gnt));
    chk({tag, ".reject"}, 32'(reject),        32'(e_rej));
    chk({tag, ".count"},  32'(count),         32'(e_cnt));
    chk({tag, ".rr_ptr"}, 32'(dut.rr_ptr_q),  32'(e_ptr));
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
  endtask

  logic [3:0] seq_gnt [5];
  logic [1:0] seq_ptr [5];

  initial begin
    reset = 1'b1;
    clear = 1'b0;
    req   = 4'b0000;
    dir   = 4'b0000;
    seq_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    seq_ptr = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    // Reset values
    tick();
    tick();
    chk_state("reset", 4'b0000, 1'b0, 4'd0, 2'd0);
    chk("reset.at_min", 32'(at_min), 32'd1);
    chk("reset.at_max", 32'(at_max), 32'd0);
    reset = 1'b0;

    // Single requester, held for two edges: second edge is masked
    req = 4'b0001; dir = 4'b0001;
    tick();
    chk_state("single.gnt", 4'b0001, 1'b0, 4'd1, 2'd1);
    chk("single.at_min", 32'(at_min), 32'd0);
    tick();
    chk_state("single.masked", 4'b0000, 1'b0, 4'd1, 2'd1);
    req = 4'b0000;
    tick();
    chk_state("single.idle", 4'b0000, 1'b0, 4'd1, 2'd1);

    // All four requesting up from count 0: round-robin rotation
    pulse_reset();
    chk_state("rr.after_reset", 4'b0000, 1'b0, 4'd0, 2'd0);
    req = 4'b1111; dir = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_state($sformatf("rr.step%0d", i), seq_gnt[i], 1'b0, 4'(i + 1), seq_ptr[i]);
    end
    // Ten more up-steps climb 5 -> 15, winners 1,2,3,0,1,2,3,0,1,2
    for (int i = 0; i < 10; i++) tick();
    chk_state("climb.top", 4'b0100, 1'b0, 4'd15, 2'd3);
    chk("climb.at_max", 32'(at_max), 32'd1);
    req = 4'b0000;
    tick();
    chk_state("climb.idle", 4'b0000, 1'b0, 4'd15, 2'd3);

    // Saturation at MAX_VAL: requester 3 up is rejected, then requester 2 down
    req = 4'b1100; dir = 4'b1000;
    tick();
    chk_state("sat.max_reject", 4'b1000, 1'b1, 4'd15, 2'd0);
    chk("sat.at_max", 32'(at_max), 32'd1);
    req = 4'b0100;
    tick();
    chk_state("sat.down", 4'b0100, 1'b0, 4'd14, 2'd3);
    chk("sat.at_max_drop", 32'(at_max), 32'd0);
    req = 4'b0000;
    tick();
    chk_state("sat.idle", 4'b0000, 1'b0, 4'd14, 2'd3);

    // Decrement at zero is rejected and count stays at 0
    pulse_reset();
    req = 4'b0010; dir = 4'b0000;
    tick();
    chk_state("min.reject", 4'b0010, 1'b1, 4'd0, 2'd2);
    chk("min.at_min", 32'(at_min), 32'd1);
    req = 4'b0000;
    tick();
    chk_state("min.idle", 4'b0000, 1'b0, 4'd0, 2'd2);

    // Climb to 9 (winners 2,3,0,1,2,3,0,1,2), then clear with requests pending
    req = 4'b1111; dir = 4'b1111;
    for (int i = 0; i < 9; i++) tick();
    chk_state("clr.pre", 4'b0100, 1'b0, 4'd9, 2'd3);
    clear = 1'b1; req = 4'b0011; dir = 4'b0011;
    tick();
    chk_state("clr.clear", 4'b0000, 1'b0, 4'd0, 2'd3);
    chk("clr.at_min", 32'(at_min), 32'd1);
    clear = 1'b0;
    tick();
    chk_state("clr.first", 4'b0001, 1'b0, 4'd1, 2'd1);
    req = 4'b0010;
    tick();
    chk_state("clr.second", 4'b0010, 1'b0, 4'd2, 2'd2);
    req = 4'b0000;
    tick();
    chk_state("clr.idle", 4'b0000, 1'b0, 4'd2, 2'd2);

    // Climb to 7 (winners 2,3,0,1,2) and hit reset mid-cycle
    req = 4'b1111; dir = 4'b1111;
    for (int i = 0; i < 5; i++) tick();
    chk_state("rst.pre", 4'b0100, 1'b0, 4'd7, 2'd3);
    reset = 1'b1;
    #1;
    chk_state("rst.async", 4'b0000, 1'b0, 4'd0, 2'd0);
    chk("rst.at_min", 32'(at_min), 32'd1);
    req = 4'b0000;
    reset = 1'b0;
    tick();
    chk_state("rst.after", 4'b0000, 1'b0, 4'd0, 2'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/counter_access_arbiter.md
Name: counter_access_arbiter

Overview:
Shares one up/down counter among NUM_REQ requesters. Each requester asks for a single increment or decrement. A round-robin arbiter grants one requester per clock and applies its step to the shared count, saturating at 0 and MAX_VAL. Used wherever several agents track one shared occupancy or credit value, for example slot or credit accounting beside the register blocks.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 4, counter width in bits
MAX_VAL, 15, upper saturation bound; must be <= 2**WIDTH-1

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
clear  input  1  synchronous clear of the count; priority over all requests
req  input  NUM_REQ  per-requester request, level, held until granted
dir  input  NUM_REQ  per-requester direction: 1=increment, 0=decrement; valid while req is high
gnt  output  NUM_REQ  one-hot grant pulse, registered, 1 cycle
reject  output  1  registered pulse: the granted op was blocked by saturation
count  output  WIDTH  shared counter value, registered
at_max  output  1  count == MAX_VAL (decoded from the count register)
at_min  output  1  count == 0 (decoded from the count register)

Behaviour:
- Reset (async, active-high): count=0, gnt=0, reject=0, rr_ptr=0, at_min=1, at_max=0.
- Eligible set each cycle: req[i] & ~gnt[i].
  - A requester whose gnt is currently high is excluded, so it is never granted twice back-to-back.
  - The requester drops req on the edge after it sees gnt.
- Arbitration is round-robin.
  - Search starts at index rr_ptr and wraps modulo NUM_REQ; the first eligible index w wins.
  - rr_ptr at reset is 0, so requester 0 has top priority.
- On the edge where winner w exists and clear=0:
  - gnt[w] <= 1 and all other gnt bits <= 0.
  - rr_ptr <= (w+1) mod NUM_REQ.
  - dir[w]=1 and count<MAX_VAL: count <= count+1, reject<=0.
  - dir[w]=1 and count==MAX_VAL: count holds, reject<=1.
  - dir[w]=0 and count>0: count <= count-1, reject<=0.
  - dir[w]=0 and count==0: count holds, reject<=1.
- Latency:
  - A req first seen high at edge k returns gnt during cycle k..k+1, if it wins.
  - The count shows the updated value in that same cycle.
- No eligible requester: gnt<=0, reject<=0, count and rr_ptr hold.
- clear=1: count<=0, gnt<=0, reject<=0, rr_ptr holds. Pending requests stay pending and are arbitrated after clear drops.
- No wrap-around under any condition. The count never leaves the range 0..MAX_VAL.
- Throughput:
  - Aggregate: one op per cycle with 2 or more active requesters.
  - Per requester: at most one op every 2 cycles.
  - Fairness: a requester holding req waits at most NUM_REQ-1 grants.
- Reset asserted mid-operation: all state returns to its reset values immediately. Any grant in flight is lost and the requester must re-request.
- dir of a requester that is not granted is ignored.

Decomposition:
- Shared package/header holds:
  - direction constants DIR_UP=1 and DIR_DOWN=0;
  - default WIDTH, MAX_VAL and NUM_REQ.
- One sub-module, rr_arbiter:
  - parameter NUM_REQ;
  - inputs: eligible vector, rr_ptr;
  - outputs: one-hot winner, valid, winner index;
  - purely combinational.
- The top level holds rr_ptr, the count datapath, saturation logic and output registers.

Test Plan:
- Reset, then req=4'b0001 with dir=1, held 2 cycles then dropped -> gnt=0001 one cycle, count=1, reject=0. The cycle after gnt produces no grant (requester masked).
- req=4'b1111 all dir=1, held continuously from count=0 -> gnt sequence 0001,0010,0100,1000,0001; count 1,2,3,4,5; rr_ptr wraps 0->1->2->3->0.
- count=15, req[2]=1 dir=0 and req[3]=1 dir=1, rr_ptr=3 -> first gnt=1000 with reject=1 and count=15; next gnt=0100, count=14, reject=0.
- count=0, a single dir=0 request -> gnt pulses, reject=1, count stays 0, at_min stays 1.
- count=9, clear=1 together with req=4'b0011 -> count=0, gnt=0, rr_ptr unchanged. After clear drops, requesters 0 and 1 are granted in round-robin order.
- reset asserted mid-stream with count=7 and gnt=0100 -> count=0, gnt=0, reject=0, rr_ptr=0 asynchronously, before the next clk edge.
